// File: rtl/piso16b8_unloader.sv
// Parallel-in / serial-out block unloader: captures DEPTH words at once and
// streams them out word 0 first over a valid/ready interface.
module piso16b8_unloader #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic                   ck,
  input  logic                   reset,
  input  logic                   load_valid,
  output logic                   load_ready,
  input  logic [WIDTH*DEPTH-1:0] load_data,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_last,
  output logic [CW-1:0]          count
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] regs_d [DEPTH];
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      regs_d[k] = regs_q[k];
    end

    case (state_q)
      IDLE: begin
        if (load_valid) begin
          for (int unsigned k = 0; k < DEPTH; k++) begin
            regs_d[k] = load_data[k*WIDTH +: WIDTH];
          end
          count_d = CW'(DEPTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (out_ready) begin
          for (int unsigned k = 0; k < DEPTH - 1; k++) begin
            regs_d[k] = regs_q[k+1];
          end
          regs_d[DEPTH-1] = '0;
          count_d = count_q - CW'(1);
          if (count_q == CW'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // flush overrides any load or beat decided above; reset still wins in the register
    if (flush) begin
      state_d = IDLE;
      count_d = '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        regs_d[k] = '0;
      end
    end
  end

  always_ff @(posedge ck) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        regs_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  // All outputs decode registered state only; no combinational path from inputs.
  assign load_ready = (state_q == IDLE);
  assign out_valid  = (state_q == SHIFT);
  assign out_data   = regs_q[0];
  assign out_last   = (state_q == SHIFT) && (count_q == CW'(1));
  assign count      = count_q;

endmodule

// File: tb/tb_piso16b8_unloader.sv
// Scoreboard bench for piso16b8_unloader: expected words are queued at load
// time and popped as beats are observed.
module tb_piso16b8_unloader;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int CW = 4;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  logic           ck = 1'b0;
  logic           reset, load_valid, load_ready, flush, out_valid, out_ready, out_last;
  logic [W*D-1:0] load_data;
  logic [W-1:0]   out_data;
  logic [CW-1:0]  count;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

  piso16b8_unloader #(.WIDTH(W), .DEPTH(D)) dut (
    .ck        (ck),
    .reset     (reset),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .load_data (load_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .count     (count)
  );

  always #5 ck = ~ck;

  task automatic tick();
    @(posedge ck);
    @(negedge ck);
  endtask

  function automatic logic [W*D-1:0] mk_block(input logic [W-1:0] base, input logic [W-1:0] step);
    logic [W*D-1:0] v;
    for (int k = 0; k < D; k++) v[k*W +: W] = base + W'(k) * step;
    return v;
  endfunction

  task automatic push_block(input logic [W-1:0] base, input logic [W-1:0] step);
    exp_t e;
    for (int k = 0; k < D; k++) begin
      e.data = base + W'(k) * step;
      e.last = (k == D - 1);
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; load_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; load_data = '0;
    tick(); tick();
    n_total++;
    if ({load_ready, out_valid, out_last, out_data, count} !== {1'b1, 1'b0, 1'b0, 16'h0, 4'h0})
      $display("FAIL reset_state act lr=%b ov=%b ol=%b od=%h cnt=%0d exp lr=1 ov=0 ol=0 od=0000 cnt=0",
               load_ready, out_valid, out_last, out_data, count);
    else n_pass++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    load_data = mk_block(16'h1111, 16'h1111); load_valid = 1'b1; push_block(16'h1111, 16'h1111);
    tick();
    load_valid = 1'b0;
    n_total++;
    if (load_ready !== 1'b0 || count !== 4'd8) $display("FAIL basic_accept act lr=%b cnt=%0d exp lr=0 cnt=8", load_ready, count);
    else n_pass++;
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin
      out_ready = 1'b1;
      if (out_valid) begin
        n_total++;
        if (out_data !== sb[0].data || out_last !== sb[0].last || count !== 4'((sb.size() - 1) % D + 1))
          $display("FAIL basic_word act %h/%b/%0d exp %h/%b/%0d", out_data, out_last, count,
                   sb[0].data, sb[0].last, (sb.size() - 1) % D + 1);
        else n_pass++;
        void'(sb.pop_front());
      end
      tick();
    end
    n_total++;
    if (sb.size() != 0) $display("FAIL basic_timeout act %0d words left exp 0", sb.size());
    else n_pass++;
    n_total++;
    if (load_ready !== 1'b1 || out_valid !== 1'b0 || count !== 4'd0 || out_data !== 16'h0)
      $display("FAIL basic_after_last act lr=%b ov=%b cnt=%0d od=%h exp lr=1 ov=0 cnt=0 od=0000",
               load_ready, out_valid, count, out_data);
    else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    load_data = mk_block(16'h1111, 16'h1111); load_valid = 1'b1; push_block(16'h1111, 16'h1111);
    tick();
    load_valid = 1'b0;
    for (int c = 0; c < 40 && sb.size() != 0; c++) begin
      out_ready = (c % 3 == 0);
      if (out_valid) begin
        n_total++;
        if (out_data !== sb[0].data || out_last !== sb[0].last || count !== 4'((sb.size() - 1) % D + 1))
          $display("FAIL bp_word c=%0d act %h/%b/%0d exp %h/%b/%0d", c, out_data, out_last, count,
                   sb[0].data, sb[0].last, (sb.size() - 1) % D + 1);
        else n_pass++;
        if (out_ready) void'(sb.pop_front());
      end else begin
        n_total++;
        $display("FAIL bp_valid_drop c=%0d act ov=0 exp ov=1", c);
      end
      tick();
    end
    n_total++;
    if (sb.size() != 0 || load_ready !== 1'b1) $display("FAIL bp_end act left=%0d lr=%b exp left=0 lr=1", sb.size(), load_ready);
    else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_load_during_shift();
    int idle_cycles = 0;
    bit second_taken = 0;
    load_data = mk_block(16'h1111, 16'h1111); load_valid = 1'b1; push_block(16'h1111, 16'h1111);
    tick();
    load_data = mk_block(16'hA000, 16'h0001); push_block(16'hA000, 16'h0001);
    for (int c = 0; c < 40 && sb.size() != 0; c++) begin
      out_ready = 1'b1;
      if (out_valid) begin
        n_total++;
        if (out_data !== sb[0].data || out_last !== sb[0].last || count !== 4'((sb.size() - 1) % D + 1))
          $display("FAIL ldshift_word act %h/%b/%0d exp %h/%b/%0d", out_data, out_last, count,
                   sb[0].data, sb[0].last, (sb.size() - 1) % D + 1);
        else n_pass++;
        void'(sb.pop_front());
        tick();
      end else begin
        idle_cycles++;
        tick();
        if (load_ready && !second_taken) ; else if (!second_taken) begin second_taken = 1; load_valid = 1'b0; end
      end
    end
    load_valid = 1'b0;
    n_total++;
    if (sb.size() != 0 || idle_cycles != 1)
      $display("FAIL ldshift_total act left=%0d idle=%0d exp left=0 idle=1", sb.size(), idle_cycles);
    else n_pass++;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_flush();
    load_data = mk_block(16'h1111, 16'h1111); load_valid = 1'b1; push_block(16'h1111, 16'h1111);
    tick();
    load_valid = 1'b0; out_ready = 1'b1;
    repeat (3) begin void'(sb.pop_front()); tick(); end
    n_total++;
    if (count !== 4'd5 || out_data !== 16'h4444) $display("FAIL flush_pre act cnt=%0d od=%h exp cnt=5 od=4444", count, out_data);
    else n_pass++;
    flush = 1'b1;
    tick();
    flush = 1'b0; sb.delete();
    n_total++;
    if (out_valid !== 1'b0 || count !== 4'd0 || load_ready !== 1'b1 || out_data !== 16'h0)
      $display("FAIL flush_post act ov=%b cnt=%0d lr=%b od=%h exp ov=0 cnt=0 lr=1 od=0000", out_valid, count, load_ready, out_data);
    else n_pass++;
    flush = 1'b1; load_valid = 1'b1;
    tick();
    flush = 1'b0; load_valid = 1'b0;
    n_total++;
    if (load_ready !== 1'b1 || count !== 4'd0) $display("FAIL flush_idle_load act lr=%b cnt=%0d exp lr=1 cnt=0", load_ready, count);
    else n_pass++;
    load_data = mk_block(16'hBEEF, 16'h0001); load_valid = 1'b1; push_block(16'hBEEF, 16'h0001);
    tick();
    load_valid = 1'b0;
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin
      if (out_valid) begin
        n_total++;
        if (out_data !== sb[0].data || out_last !== sb[0].last)
          $display("FAIL flush_reload act %h/%b exp %h/%b", out_data, out_last, sb[0].data, sb[0].last);
        else n_pass++;
        void'(sb.pop_front());
      end
      tick();
    end
    n_total++;
    if (sb.size() != 0) $display("FAIL flush_reload_timeout act left=%0d exp 0", sb.size());
    else n_pass++;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    load_data = mk_block(16'h1111, 16'h1111); load_valid = 1'b1;
    tick();
    load_valid = 1'b0; out_ready = 1'b1;
    repeat (4) tick();
    n_total++;
    if (count !== 4'd4) $display("FAIL rst_pre act cnt=%0d exp 4", count);
    else n_pass++;
    reset = 1'b1; flush = 1'b1; load_valid = 1'b1; load_data = mk_block(16'h5555, 16'h0001);
    tick();
    reset = 1'b0; flush = 1'b0; load_valid = 1'b0; out_ready = 1'b0;
    n_total++;
    if ({load_ready, out_valid, out_last, out_data, count} !== {1'b1, 1'b0, 1'b0, 16'h0, 4'h0})
      $display("FAIL rst_mid act lr=%b ov=%b ol=%b od=%h cnt=%0d exp lr=1 ov=0 ol=0 od=0000 cnt=0",
               load_ready, out_valid, out_last, out_data, count);
    else n_pass++;
    load_data = mk_block(16'h1111, 16'h1111); load_valid = 1'b1;
    tick();
    load_valid = 1'b0;
    reset = 1'b1;
    #2;
    n_total++;
    if (out_valid !== 1'b1 || count !== 4'd8 || out_data !== 16'h1111)
      $display("FAIL rst_no_edge act ov=%b cnt=%0d od=%h exp ov=1 cnt=8 od=1111", out_valid, count, out_data);
    else n_pass++;
    reset = 1'b0;
    @(negedge ck);
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    int accepts = 0;
    int last_acc = 0;
    load_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 60 && (accepts < 3 || sb.size() != 0); c++) begin
      if (load_ready && accepts < 3) begin
        if (accepts > 0) begin
          n_total++;
          if (c - last_acc != D + 1) $display("FAIL b2b_period act %0d exp %0d", c - last_acc, D + 1);
          else n_pass++;
        end
        load_data = mk_block(16'hC000 + W'(accepts) * 16'h0100, 16'h0001);
        push_block(16'hC000 + W'(accepts) * 16'h0100, 16'h0001);
        last_acc = c;
        accepts++;
      end
      if (accepts == 3 && !load_ready) load_valid = 1'b0;
      if (out_valid) begin
        n_total++;
        if (out_data !== sb[0].data || out_last !== sb[0].last || count !== 4'((sb.size() - 1) % D + 1))
          $display("FAIL b2b_word act %h/%b/%0d exp %h/%b/%0d", out_data, out_last, count,
                   sb[0].data, sb[0].last, (sb.size() - 1) % D + 1);
        else n_pass++;
        void'(sb.pop_front());
      end
      tick();
    end
    load_valid = 1'b0; out_ready = 1'b0;
    n_total++;
    if (sb.size() != 0 || accepts != 3) $display("FAIL b2b_end act left=%0d acc=%0d exp left=0 acc=3", sb.size(), accepts);
    else n_pass++;
  endtask

  initial begin
    @(negedge ck);
    test_reset();
    test_basic();
    test_backpressure();
    test_load_during_shift();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
